grid_sweep_ctrl: RTL and testbench

Sequencing controller for the paper-grid removal datapath. Loads a DEPTH x WIDTH occupancy grid (1 = paper, 0 = empty) over a row-stream handshake, then runs repeated removal sweeps until a sweep removes nothing or a pass limit is hit. Each sweep is row-serial, with one row per cycle, and gives exact simultaneous-removal semantics. Reports the total removed count, the pass count and a convergence flag to the puzzle top level.

---
 rtl/grid_sweep_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_grid_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_sweep_ctrl.sv
// Paper-grid removal sequencer: loads a DEPTH x WIDTH grid, sweeps it row-serially until stable or pass-limited.
// Optional final-grid drain over out_row is compiled in with GRID_DRAIN_EN.
module grid_sweep_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_PASSES = 255,
  localparam int unsigned TW = $clog2(WIDTH*DEPTH+1),
  localparam int unsigned PW = $clog2(MAX_PASSES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TW-1:0]    total,
  output logic [PW-1:0]    passes,
  output logic             converged,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row
);

  localparam int unsigned RW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SWEEP, S_CHECK, S_RESULT
`ifdef GRID_DRAIN_EN
    , S_DRAIN
`endif
  } state_t;

  state_t           state, state_n;
  logic [RW-1:0]    row_ptr, row_ptr_n;
  logic [WIDTH-1:0] prev_row, prev_n;
  logic [TW-1:0]    acc, acc_n, total_n;
  logic [PW-1:0]    passes_n;
  logic             conv_n;
  logic             grid_we;
  logic [WIDTH-1:0] grid_wd;
  logic [WIDTH-1:0] grid [DEPTH];

  logic [WIDTH-1:0] cur_row, nxt_row, new_row;
  logic [WIDTH+1:0] p_pad, c_pad, n_pad;
  logic [3:0]       nbr;
  logic [CW-1:0]    row_removed;

  // Survivor rule for the row under row_ptr; out-of-grid neighbours read as 0
  always_comb begin
    cur_row     = grid[row_ptr];
    nxt_row     = '0;
    if (row_ptr != LAST_ROW) nxt_row = grid[row_ptr + RW'(1)];
    p_pad       = {1'b0, prev_row, 1'b0};
    c_pad       = {1'b0, cur_row, 1'b0};
    n_pad       = {1'b0, nxt_row, 1'b0};
    new_row     = '0;
    row_removed = '0;
    nbr         = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      nbr = 4'(p_pad[j]) + 4'(p_pad[j+1]) + 4'(p_pad[j+2]) +
            4'(c_pad[j]) + 4'(c_pad[j+2]) +
            4'(n_pad[j]) + 4'(n_pad[j+1]) + 4'(n_pad[j+2]);
      new_row[j]  = cur_row[j] & (nbr >= 4'd4);
      row_removed = row_removed + CW'(cur_row[j] & ~new_row[j]);
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_n   = state;
    row_ptr_n = row_ptr;
    prev_n    = prev_row;
    acc_n     = acc;
    total_n   = total;
    passes_n  = passes;
    conv_n    = converged;
    grid_we   = 1'b0;
    grid_wd   = in_row;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          total_n   = '0;
          passes_n  = '0;
          acc_n     = '0;
          row_ptr_n = '0;
          state_n   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          grid_we = 1'b1;
          if (row_ptr == LAST_ROW) begin
            row_ptr_n = '0;
            prev_n    = '0;
            state_n   = S_SWEEP;
          end else begin
            row_ptr_n = row_ptr + RW'(1);
          end
        end
      end
      S_SWEEP: begin
        grid_we = 1'b1;
        grid_wd = new_row;
        prev_n  = cur_row;
        acc_n   = acc + TW'(row_removed);
        if (row_ptr == LAST_ROW) begin
          row_ptr_n = '0;
          state_n   = S_CHECK;
        end else begin
          row_ptr_n = row_ptr + RW'(1);
        end
      end
      S_CHECK: begin
        prev_n = '0;
        if (acc == '0) begin
          conv_n  = 1'b1;
          state_n = S_RESULT;
        end else begin
          total_n  = total + acc;
          passes_n = passes + PW'(1);
          acc_n    = '0;
          if (passes_n == PW'(MAX_PASSES)) begin
            conv_n  = 1'b0;
            state_n = S_RESULT;
          end else begin
            state_n = S_SWEEP;
          end
        end
      end
      S_RESULT: begin
        if (res_valid && res_ready) begin
`ifdef GRID_DRAIN_EN
          row_ptr_n = '0;
          state_n   = S_DRAIN;
`else
          state_n   = S_IDLE;
`endif
        end
      end
`ifdef GRID_DRAIN_EN
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          if (row_ptr == LAST_ROW) begin
            row_ptr_n = '0;
            state_n   = S_IDLE;
          end else begin
            row_ptr_n = row_ptr + RW'(1);
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      row_ptr   <= '0;
      prev_row  <= '0;
      acc       <= '0;
      total     <= '0;
      passes    <= '0;
      converged <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      row_ptr   <= row_ptr_n;
      prev_row  <= prev_n;
      acc       <= acc_n;
      total     <= total_n;
      passes    <= passes_n;
      converged <= conv_n;
      in_ready  <= (state_n == S_LOAD);
      res_valid <= (state_n == S_RESULT);
      busy      <= (state_n != S_IDLE);
    end
  end

  // Grid storage carries no reset; every job overwrites it during LOAD
  always_ff @(posedge clk) begin
    if (grid_we) grid[row_ptr] <= grid_wd;
  end

`ifdef GRID_DRAIN_EN
  logic [WIDTH-1:0] out_row_n;

  always_comb begin
    out_row_n = '0;
    if (state_n == S_DRAIN) out_row_n = grid[row_ptr_n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      out_valid <= (state_n == S_DRAIN);
      out_row   <= out_row_n;
    end
  end
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign out_valid        = 1'b0;
  assign out_row          = '0;
`endif

endmodule

// File: tb/tb_grid_sweep_ctrl.sv
// Bench for grid_sweep_ctrl: directed and random grids against a cell-level removal model.
// Two instances: default pass limit and MAX_PASSES = 2, selected by sel.
module tb_grid_sweep_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned TW = $clog2(W*D+1);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, in_valid = 1'b0, res_ready = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_row = '0;
  logic         sel = 1'b0;

  logic          in_ready_a, res_valid_a, conv_a, busy_a, out_valid_a;
  logic [TW-1:0] total_a;
  logic [7:0]    passes_a;
  logic [W-1:0]  out_row_a;
  logic          in_ready_b, res_valid_b, conv_b, busy_b, out_valid_b;
  logic [TW-1:0] total_b;
  logic [1:0]    passes_b;
  logic [W-1:0]  out_row_b;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] g_in  [D];
  logic [W-1:0] g_fin [D];

  always #5 clk = ~clk;

  grid_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_PASSES(255)) u_a (
    .clk(clk), .reset(reset), .start(start & ~sel),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_row(in_row),
    .res_valid(res_valid_a), .res_ready(res_ready & ~sel),
    .total(total_a), .passes(passes_a), .converged(conv_a), .busy(busy_a),
    .out_valid(out_valid_a), .out_ready(out_ready & ~sel), .out_row(out_row_a));

  grid_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_PASSES(2)) u_b (
    .clk(clk), .reset(reset), .start(start & sel),
    .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_row(in_row),
    .res_valid(res_valid_b), .res_ready(res_ready & sel),
    .total(total_b), .passes(passes_b), .converged(conv_b), .busy(busy_b),
    .out_valid(out_valid_b), .out_ready(out_ready & sel), .out_row(out_row_b));

  wire          in_ready_m  = sel ? in_ready_b  : in_ready_a;
  wire          res_valid_m = sel ? res_valid_b : res_valid_a;
  wire          conv_m      = sel ? conv_b      : conv_a;
  wire          busy_m      = sel ? busy_b      : busy_a;
  wire          out_valid_m = sel ? out_valid_b : out_valid_a;
  wire [W-1:0]  out_row_m   = sel ? out_row_b   : out_row_a;
  wire [31:0]   total_m     = sel ? 32'(total_b)  : 32'(total_a);
  wire [31:0]   passes_m    = sel ? 32'(passes_b) : 32'(passes_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Whole-grid simultaneous removal, repeated until nothing goes or the limit is hit
  task automatic model(input int maxp, output int tot, output int pas, output int conv, output int sweeps);
    bit cur [D][W];
    bit nxt [D][W];
    int rem, n;
    for (int r = 0; r < D; r++) for (int c = 0; c < W; c++) cur[r][c] = g_in[r][c];
    tot = 0; pas = 0; conv = 0; sweeps = 0;
    for (int s = 0; s < 400; s++) begin
      rem = 0;
      for (int r = 0; r < D; r++) begin
        for (int c = 0; c < W; c++) begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < D && c+dc >= 0 && c+dc < W)
                n += int'(cur[r+dr][c+dc]);
          nxt[r][c] = cur[r][c] && (n >= 4);
          if (cur[r][c] && !nxt[r][c]) rem++;
        end
      end
      sweeps++;
      if (rem == 0) begin conv = 1; break; end
      tot += rem; pas++;
      cur = nxt;
      if (pas == maxp) begin conv = 0; break; end
    end
    for (int r = 0; r < D; r++) for (int c = 0; c < W; c++) g_fin[r][c] = cur[r][c];
  endtask

  // Start a job and stream g_in; returns edges from the start edge to the last accepted beat
  task automatic load_grid(input int stall_at, input int n_stall, output int k);
    int i, left;
    bit fire;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; i = 0; left = n_stall;
    while (i < D && k < 500) begin
      if (i == stall_at && left > 0) begin in_valid = 1'b0; left--; end
      else begin in_valid = 1'b1; in_row = g_in[i]; end
      fire = in_valid && in_ready_m;
      @(posedge clk); #1;
      k++;
      if (fire) i++;
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_m),  0);
    chk({tag, "_res_valid"}, 32'(res_valid_m), 0);
    chk({tag, "_out_valid"}, 32'(out_valid_m), 0);
    chk({tag, "_busy"},      32'(busy_m),      0);
    chk({tag, "_converged"}, 32'(conv_m),      0);
    chk({tag, "_total"},     total_m,          0);
    chk({tag, "_passes"},    passes_m,         0);
    chk({tag, "_out_row"},   32'(out_row_m),   0);
  endtask

  // Full job: load, wait for result, optional hold/start pokes, handshake, drain
  task automatic run_job(input string tag, input int stall_at, input int n_stall, input int hold,
                         input bit poke, input int x_tot, input int x_pas, input int x_conv);
    int e_tot, e_pas, e_conv, e_sw, k, k_last, i;
    bit fire;
    model(sel ? 2 : 255, e_tot, e_pas, e_conv, e_sw);
    load_grid(stall_at, n_stall, k);
    k_last = k;
    chk({tag, "_load_edges"}, k_last, D + n_stall);
    chk({tag, "_busy_sweep"}, 32'(busy_m), 1);
    chk({tag, "_in_ready_off"}, 32'(in_ready_m), 0);
    while (!res_valid_m && k < k_last + 300*(D+1)) begin
      start = poke && (k == k_last + 3);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({tag, "_res_valid"}, 32'(res_valid_m), 1);
    chk({tag, "_latency"}, k - k_last, e_sw * (D+1));
    chk({tag, "_total"}, total_m, e_tot);
    chk({tag, "_passes"}, passes_m, e_pas);
    chk({tag, "_converged"}, 32'(conv_m), e_conv);
    if (x_tot >= 0) begin
      chk({tag, "_total_plan"}, total_m, x_tot);
      chk({tag, "_passes_plan"}, passes_m, x_pas);
      chk({tag, "_conv_plan"}, 32'(conv_m), x_conv);
    end
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 1);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(res_valid_m), 1);
      chk({tag, "_hold_total"}, total_m, e_tot);
      chk({tag, "_hold_passes"}, passes_m, e_pas);
      chk({tag, "_hold_conv"}, 32'(conv_m), e_conv);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_res_drop"}, 32'(res_valid_m), 0);
`ifdef GRID_DRAIN_EN
    i = 0; k = 0;
    while (i < D && k < 200) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid_m && out_ready) chk({tag, "_drain_row"}, 32'(out_row_m), 32'(g_fin[i]));
      fire = out_valid_m && out_ready;
      @(posedge clk); #1;
      k++;
      if (fire) i++;
    end
    out_ready = 1'b0;
    chk({tag, "_drain_count"}, i, D);
`else
    i = 0; k = 0; fire = 1'b0;
`endif
    chk({tag, "_busy_done"}, 32'(busy_m), 0);
  endtask

  initial begin
    int k, dens;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    reset = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < D; r++) g_in[r] = '0;
    run_job("zero", 0, 0, 0, 1'b0, 0, 0, 1);

    for (int r = 0; r < D; r++) g_in[r] = '1;
    run_job("ones", 0, 0, 2, 1'b0, 4, 1, 1);

    for (int r = 0; r < D; r++) g_in[r] = (r >= 5 && r <= 7) ? 16'h00E0 : 16'h0000;
    run_job("blk", 0, 0, 5, 1'b1, 9, 3, 1);
    sel = 1'b1;
    run_job("blk_mp2", 0, 0, 1, 1'b0, 8, 2, 0);
    sel = 1'b0;

    for (int r = 0; r < D; r++) g_in[r] = W'(1) << r;
    run_job("diag", 0, 0, 0, 1'b0, 16, 1, 1);
    run_job("diag_stall", 7, 3, 0, 1'b0, 16, 1, 1);

    for (int t = 0; t < 10; t++) begin
      dens = $urandom_range(35, 95);
      for (int r = 0; r < D; r++)
        for (int c = 0; c < W; c++) g_in[r][c] = ($urandom_range(0, 99) < dens);
      sel = (t % 4 == 3);
      run_job("rand", $urandom_range(0, D-1), $urandom_range(0, 4), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), -1, -1, -1);
    end
    sel = 1'b0;

    // Abort mid-sweep; registered outputs must clear asynchronously
    for (int r = 0; r < D; r++) g_in[r] = '1;
    load_grid(D, 0, k);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy_m), 1);
    reset = 1'b0;
    #1;
    chk_reset("abort");
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_busy", 32'(busy_m), 0);
    for (int r = 0; r < D; r++) g_in[r] = '0;
    run_job("post_abort", 0, 0, 0, 1'b0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
